// File: rtl/jk_bank_sequencer_pkg.sv
// Shared definitions for the JK bank sequencer: command opcodes, FSM states
// and a helper classifying which opcodes honour the command length field.
package jk_bank_sequencer_pkg;

    typedef enum logic [2:0] {
        OP_NOP        = 3'd0,
        OP_LOAD       = 3'd1,
        OP_CLEAR      = 3'd2,
        OP_SET        = 3'd3,
        OP_TOGGLE     = 3'd4,
        OP_COUNT_UP   = 3'd5,
        OP_SHIFT_LEFT = 3'd6,
        OP_RSVD       = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Only COUNT_UP and SHIFT_LEFT run for cmd_len cycles; all others run one.
    function automatic logic op_is_multi(input op_e op);
        return (op == OP_COUNT_UP) || (op == OP_SHIFT_LEFT);
    endfunction

endpackage

// File: rtl/jk_bank_sequencer_jk_cell.sv
// Single JK flip-flop, asynchronous active-low reset to 0.
// J K : 00 hold, 01 reset, 10 set, 11 toggle.
module jk_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic j_i,
    input  logic k_i,
    output logic q_o
);

    logic q_q;
    logic q_d;

    // Next state from the JK truth table.
    always_comb begin
        q_d = q_q;
        unique case ({j_i, k_i})
            2'b00:   q_d = q_q;
            2'b01:   q_d = 1'b0;
            2'b10:   q_d = 1'b1;
            default: q_d = ~q_q;
        endcase
    end

    // Flop storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_q <= 1'b0;
        else        q_q <= q_d;
    end

    assign q_o = q_q;

endmodule

// File: rtl/jk_bank_sequencer.sv
// Command-driven sequencer for a bank of WIDTH JK flip-flops.
// FSM IDLE -> EXEC -> DONE -> IDLE; J/K decoded from the latched command.
// Optional feature: define JK_SEQ_WRAP_FLAG_EN to add the 'wrap' output,
// a one-cycle flag following each COUNT_UP edge that rolls all-1s over to 0.
module jk_bank_sequencer
    import jk_bank_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_len,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar
`ifdef JK_SEQ_WRAP_FLAG_EN
    ,
    output logic             wrap
`endif
);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] j_w, k_w;
    logic             carry;

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_EXEC) || (state_q == ST_DONE);
    assign done      = (state_q == ST_DONE);
    assign qbar      = ~q;

    // FSM state and latched command registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            data_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
        end
    end

    // Next-state: accept in IDLE, count down in EXEC, single DONE cycle.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        rem_d   = rem_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d    = op_e'(cmd_op);
                    data_d  = cmd_data;
                    state_d = ST_EXEC;
                    if (op_is_multi(op_e'(cmd_op)) && (cmd_len != '0)) rem_d = cmd_len;
                    else                                              rem_d = CNT_W'(1);
                end
            end
            ST_EXEC: begin
                rem_d = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // J/K decode: hold outside EXEC, otherwise per latched opcode.
    always_comb begin
        j_w   = '0;
        k_w   = '0;
        carry = 1'b1;
        if (state_q == ST_EXEC) begin
            unique case (op_q)
                OP_LOAD: begin
                    j_w = data_q;
                    k_w = ~data_q;
                end
                OP_CLEAR: k_w = '1;
                OP_SET:   j_w = '1;
                OP_TOGGLE: begin
                    j_w = data_q;
                    k_w = data_q;
                end
                OP_COUNT_UP: begin
                    // Each bit toggles when all lower bits are 1 (ripple carry).
                    for (int unsigned i = 0; i < WIDTH; i++) begin
                        j_w[i] = carry;
                        k_w[i] = carry;
                        carry  = carry & q[i];
                    end
                end
                OP_SHIFT_LEFT: begin
                    j_w[0] = data_q[0];
                    k_w[0] = ~data_q[0];
                    for (int unsigned i = 1; i < WIDTH; i++) begin
                        j_w[i] = q[i-1];
                        k_w[i] = ~q[i-1];
                    end
                end
                default: begin
                    j_w = '0;
                    k_w = '0;
                end
            endcase
        end
    end

    // Flip-flop bank.
    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .j_i   (j_w[g]),
            .k_i   (k_w[g]),
            .q_o   (q[g])
        );
    end

`ifdef JK_SEQ_WRAP_FLAG_EN
    logic wrap_q;

    // Flag the cycle after a COUNT_UP edge that rolls all-1s over to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wrap_q <= 1'b0;
        else        wrap_q <= (state_q == ST_EXEC) && (op_q == OP_COUNT_UP) && (&q);
    end

    assign wrap = wrap_q;
`endif

endmodule
